block_sync_rx: RTL and testbench
================================

// Module: block_sync_rx
// PURPOSE
//  64b/66b receive block lock for one PCS lane (IEEE 802.3 Cl.49 fig 49-14 lock FSM, cycle-optimised).
//  Watches sync headers from the rx gearbox and slips the gearbox until headers are consistently valid.
//  Asserts lock_o for the descrambler/decoder downstream. One instance per lane: 1 for 10G, 4 for 40G.
// PARAMETERS
//  HEAD_W      2   sync header width
//  SH_CNT_MAX  64  headers per test window
//  SH_INV_MAX  16  invalid headers in one window that break an existing lock
//  SLIP_WAIT_N 2   head_v_i beats ignored after a slip while the gearbox realigns (>=1)
// PORTS
//  clk          in   1       clock
//  nreset       in   1       asynchronous active-low reset
//  signal_ok_i  in   1       PMA signal detect; low forces the FSM back to INIT
//  head_v_i     in   1       head_i holds a new sync header this cycle
//  head_i       in   HEAD_W  sync header from the rx gearbox
//  slip_v_o     out  1       one-cycle pulse: gearbox shifts its alignment by one bit
//  lock_o       out  1       block lock achieved
//  slip_cnt_o   out  16      slips since reset (only with BLOCK_SYNC_SLIP_CNT_EN)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk, nreset); all else is synchronous.
//  Reset: state=INIT, lock_o=0, slip_v_o=0, sh_cnt=0, inv_cnt=0, wait_cnt=0, slip_cnt_o=0.
//  Header valid: head_i==2'b01 (data) or 2'b10 (ctrl); 2'b00 and 2'b11 are invalid.
//  Counters: sh_cnt is $clog2(SH_CNT_MAX+1) bits; inv_cnt is $clog2(SH_INV_MAX+1) bits. They never wrap.
//  States:
//   INIT : clear counters, keep lock_o; next cycle -> TEST. head_v_i is ignored.
//   TEST : only head_v_i beats are evaluated, so gaps in head_v_i are harmless.
//          On each beat, sh_n=sh_cnt+1 and inv_n=inv_cnt+(invalid).
//          Priority 1: invalid && (!lock_o || inv_n==SH_INV_MAX) -> SLIP; lock_o<=0 next cycle.
//          Priority 2: sh_n==SH_CNT_MAX -> clear counters, stay in TEST;
//                      lock_o<=1 if inv_n==0, otherwise lock_o is unchanged.
//          Otherwise: sh_cnt<=sh_n, inv_cnt<=inv_n.
//   SLIP : slip_v_o=1 for exactly this cycle; counters cleared; head_v_i ignored; -> WAIT.
//   WAIT : count SLIP_WAIT_N head_v_i beats, discarding their headers; after the last one -> TEST
//          with counters cleared.
//  Latency: lock_o rises the cycle after the 64th consecutive valid header beat.
//           slip_v_o rises the cycle after the offending header beat.
//  signal_ok_i low (any state): next cycle state=INIT, lock_o=0, slip_v_o=0. It has priority over
//   every transition. While it stays low the FSM remains in INIT.
//  nreset asserted mid-operation: all outputs drop immediately (async); recovery restarts from INIT.
//  Unlocked: a single invalid header slips. Locked: a window with 1..15 invalid headers keeps lock.
// CONFIGURATION
//  BLOCK_SYNC_SLIP_CNT_EN defined: slip_cnt_o counts SLIP entries, saturating at 16'hFFFF, and is
//   cleared only by nreset.
//  BLOCK_SYNC_SLIP_CNT_EN undefined: slip_cnt_o port and counter are absent; FSM behaviour is identical.
// STRUCTURE
//  Shared package pcs_rx_pkg: SYNC_HEAD_DATA=2'b01, SYNC_HEAD_CTRL=2'b10, HEAD_W,
//   block_sync_fsm_e {INIT,TEST,SLIP,WAIT}.
//  Single flat module, no sub-module. pcs_rx instantiates one block_sync_rx per lane;
//   slip_v_o feeds gearbox_rx.
// TESTING
//  1. Reset, then 64 beats head_i=01 -> lock_o=1 on the cycle after beat 64, slip_v_o stays 0.
//  2. Unlocked, first beat head_i=00 -> slip_v_o=1 for one cycle; next 2 beats of 00 ignored (no slip);
//     then 64 good beats -> lock.
//  3. Locked; 15 beats of 11 spread over one 64-beat window -> lock_o stays 1, no slip.
//     Then 16 invalid beats in the next window -> lock_o=0 and one slip_v_o pulse the cycle after
//     the 16th.
//  4. head_v_i toggling every other cycle with 64 good headers -> lock on the 64th beat;
//     head_i changes while head_v_i=0 have no effect.
//  5. Locked; signal_ok_i=0 for 1 cycle -> lock_o=0 next cycle, FSM in INIT, no slip.
//     nreset pulse mid-window -> lock_o=0 asynchronously.
//  6. BLOCK_SYNC_SLIP_CNT_EN: 5 forced slips -> slip_cnt_o=5.
//     Compile without the macro -> lint clean, scenarios 1-5 pass.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared PCS receive definitions: sync header encodings, header width and
// the block-lock state type used by block_sync_rx.
package pcs_rx_pkg;

  localparam int HEAD_W = 2;

  localparam logic [HEAD_W-1:0] SYNC_HEAD_DATA = 2'b01;
  localparam logic [HEAD_W-1:0] SYNC_HEAD_CTRL = 2'b10;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    TEST = 2'd1,
    SLIP = 2'd2,
    WAIT = 2'd3
  } block_sync_fsm_e;

  // A sync header is valid only when its two bits differ (data or control).
  function automatic logic head_is_valid(input logic [HEAD_W-1:0] head);
    return (head == SYNC_HEAD_DATA) || (head == SYNC_HEAD_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_rx.sv
// 64b/66b receive block lock for one PCS lane.
// Watches sync headers from the rx gearbox, pulses slip_v_o to shift the
// gearbox alignment by one bit until headers are consistently valid, and
// raises lock_o for the downstream descrambler/decoder.
// Optional feature: define BLOCK_SYNC_SLIP_CNT_EN to add the saturating
// slip_cnt_o counter; without it the port and counter are absent.
//
// state | meaning
// INIT  | counters cleared, head_v_i ignored, lock_o held
// TEST  | evaluate each header beat, count windows, decide lock/slip
// SLIP  | slip_v_o high for this cycle, head_v_i ignored
// WAIT  | discard SLIP_WAIT_N beats while the gearbox realigns
module block_sync_rx
  import pcs_rx_pkg::*;
#(
  parameter int SH_CNT_MAX  = 64,
  parameter int SH_INV_MAX  = 16,
  parameter int SLIP_WAIT_N = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_ok_i,
  input  logic              head_v_i,
  input  logic [HEAD_W-1:0] head_i,
  output logic              slip_v_o,
  output logic              lock_o
`ifdef BLOCK_SYNC_SLIP_CNT_EN
  ,
  output logic [15:0]       slip_cnt_o
`endif
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INV_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_N + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INV_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_N);

  block_sync_fsm_e    state;
  logic [SH_W-1:0]    sh_cnt;
  logic [INV_W-1:0]   inv_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               head_bad;
  logic [SH_W-1:0]    sh_n;
  logic [INV_W-1:0]   inv_n;
  logic [WAIT_W-1:0]  wait_n;
  logic               slip_req;

  // Next-count values for the current header beat and the slip decision.
  always_comb begin
    head_bad = !head_is_valid(head_i);
    sh_n     = sh_cnt + 1'b1;
    inv_n    = inv_cnt + INV_W'(head_bad);
    wait_n   = wait_cnt + 1'b1;
    slip_req = signal_ok_i && (state == TEST) && head_v_i && head_bad &&
               (!lock_o || (inv_n == INV_LAST));
  end

  // Lock FSM with registered lock/slip outputs and window counters.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= INIT;
      lock_o   <= 1'b0;
      slip_v_o <= 1'b0;
      sh_cnt   <= '0;
      inv_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      slip_v_o <= 1'b0;
      if (!signal_ok_i) begin
        state    <= INIT;
        lock_o   <= 1'b0;
        sh_cnt   <= '0;
        inv_cnt  <= '0;
        wait_cnt <= '0;
      end else begin
        case (state)
          INIT: begin
            sh_cnt   <= '0;
            inv_cnt  <= '0;
            wait_cnt <= '0;
            state    <= TEST;
          end
          TEST: begin
            if (head_v_i) begin
              if (slip_req) begin
                state    <= SLIP;
                slip_v_o <= 1'b1;
                lock_o   <= 1'b0;
                sh_cnt   <= '0;
                inv_cnt  <= '0;
              end else if (sh_n == SH_LAST) begin
                sh_cnt  <= '0;
                inv_cnt <= '0;
                if (inv_n == '0) begin
                  lock_o <= 1'b1;
                end
              end else begin
                sh_cnt  <= sh_n;
                inv_cnt <= inv_n;
              end
            end
          end
          SLIP: begin
            sh_cnt   <= '0;
            inv_cnt  <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (head_v_i) begin
              if (wait_n == WAIT_LAST) begin
                wait_cnt <= '0;
                sh_cnt   <= '0;
                inv_cnt  <= '0;
                state    <= TEST;
              end else begin
                wait_cnt <= wait_n;
              end
            end
          end
          default: state <= INIT;
        endcase
      end
    end
  end

`ifdef BLOCK_SYNC_SLIP_CNT_EN
  // Saturating count of SLIP entries; only nreset clears it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slip_cnt_o <= '0;
    end else if (slip_req && (slip_cnt_o != 16'hFFFF)) begin
      slip_cnt_o <= slip_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_block_sync_rx.sv
// Self-checking bench for block_sync_rx. Each beat pushes the expected
// {lock_o, slip_v_o} for the following cycle onto a scoreboard queue; the
// observed pair is queued after the edge and each test drains both queues.
module tb_block_sync_rx;

  logic       clk;
  logic       nreset;
  logic       signal_ok_i;
  logic       head_v_i;
  logic [1:0] head_i;
  logic       slip_v_o;
  logic       lock_o;
`ifdef BLOCK_SYNC_SLIP_CNT_EN
  logic [15:0] slip_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  block_sync_rx dut (
    .clk         (clk),
    .nreset      (nreset),
    .signal_ok_i (signal_ok_i),
    .head_v_i    (head_v_i),
    .head_i      (head_i),
    .slip_v_o    (slip_v_o),
    .lock_o      (lock_o)
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    ,
    .slip_cnt_o  (slip_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; expected outputs after the edge go to exp_q.
  task automatic drive(input logic v, input logic [1:0] h,
                       input logic exp_lock, input logic exp_slip);
    head_v_i = v;
    head_i   = h;
    exp_q.push_back({exp_lock, exp_slip});
    @(posedge clk);
    #1;
    obs_q.push_back({lock_o, slip_v_o});
  endtask

  task automatic apply_reset();
    nreset      = 1'b0;
    signal_ok_i = 1'b1;
    head_v_i    = 1'b0;
    head_i      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    int idx;
    apply_reset();
    n_checks++;
    if ({lock_o, slip_v_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: lock/slip got %b expected 00", {lock_o, slip_v_o});
    end
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    n_checks++;
    if (slip_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_slip_cnt: got %0d expected 0", slip_cnt_o);
    end
`endif
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) drive(1'b1, 2'b01, (i == 64), 1'b0);
    drive(1'b0, 2'b11, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL first_lock cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_slip_unlocked();
    int idx;
    apply_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1);
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++)
      drive(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, (i == 64), 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL slip_unlocked cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_locked_tolerance();
    int idx;
    for (int i = 0; i < 64; i++) begin
      if ((i % 4 == 1) && (i < 60)) drive(1'b1, 2'b11, 1'b1, 1'b0);
      else                          drive(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 16; i++)
      drive(1'b1, (i % 2 == 0) ? 2'b11 : 2'b00, (i < 16), (i == 16));
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL locked_tolerance cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_gapped_valid();
    int idx;
    apply_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      drive(1'b0, (i % 2 == 0) ? 2'b00 : 2'b11, (i > 1) && 1'b0, 1'b0);
      drive(1'b1, 2'b10, (i == 64), 1'b0);
    end
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gapped_valid cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_signal_loss();
    int idx;
    signal_ok_i = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    signal_ok_i = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) drive(1'b1, 2'b01, (i == 64), 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 2'b10, 1'b1, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL signal_loss cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
    #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({lock_o, slip_v_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: lock/slip got %b expected 00", {lock_o, slip_v_o});
    end
    @(posedge clk);
    #1;
    nreset = 1'b1;
    drive(1'b1, 2'b01, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_recovery cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
  endtask

`ifdef BLOCK_SYNC_SLIP_CNT_EN
  task automatic test_slip_cnt();
    int idx;
    apply_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b1);
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 1'b0, 1'b0);
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [1:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL slip_cnt_seq cycle %0d: lock/slip got %b expected %b", idx, o, e);
      end
      idx++;
    end
    n_checks++;
    if (slip_cnt_o !== 16'd5) begin
      n_fail++;
      $display("FAIL slip_cnt: got %0d expected 5", slip_cnt_o);
    end
  endtask
`endif

  initial begin
    nreset      = 1'b0;
    signal_ok_i = 1'b1;
    head_v_i    = 1'b0;
    head_i      = 2'b00;
    test_reset();
    test_slip_unlocked();
    test_locked_tolerance();
    test_gapped_valid();
    test_signal_loss();
`ifdef BLOCK_SYNC_SLIP_CNT_EN
    test_slip_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
